// File: rtl/riscv_mu_data_mem_responder.sv
// rtl/riscv_mu_data_mem_responder.sv - data-memory responder with fixed LATENCY and one-deep pending slots
// Optional feature: DMEM_ADDR_CHECK_EN flags misaligned / out-of-range addresses via o_mem_err.
module riscv_mu_data_mem_responder #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                enable,
    input  logic                i_mem_rd_ready,
    input  logic [ADDR_W-1:0]   i_mem_rd_addr,
    output logic                o_mem_rd_valid,
    output logic [DATA_W-1:0]   o_mem_rd_data,
    input  logic                i_mem_wr_valid,
    input  logic [ADDR_W-1:0]   i_mem_wr_addr,
    input  logic [DATA_W-1:0]   i_mem_wr_data,
    input  logic [DATA_W/8-1:0] i_mem_wr_strb,
    output logic                o_mem_wr_ready,
    output logic                o_mem_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [3:0] LAT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_WAIT = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0]   cur_data_q, cur_data_d;
    logic [STRB_W-1:0]   cur_strb_q, cur_strb_d;
    logic                pend_rd_q, pend_rd_d;
    logic [ADDR_W-1:0]   pend_rd_addr_q, pend_rd_addr_d;
    logic                pend_wr_q, pend_wr_d;
    logic [ADDR_W-1:0]   pend_wr_addr_q, pend_wr_addr_d;
    logic [DATA_W-1:0]   pend_wr_data_q, pend_wr_data_d;
    logic [STRB_W-1:0]   pend_wr_strb_q, pend_wr_strb_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [IDX_W-1:0]    idx;
    logic                cur_err;
    logic [DATA_W-1:0]   rd_word;
    logic                wr_fire;

    assign idx = cur_addr_q[IDX_W+1:2];

`ifdef DMEM_ADDR_CHECK_EN
    localparam logic [ADDR_W-3:0] DEPTH_WORDS = (ADDR_W-2)'(DEPTH);
    assign cur_err = (cur_addr_q[1:0] != 2'b00) || (cur_addr_q[ADDR_W-1:2] >= DEPTH_WORDS);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^cur_addr_q;
    assign cur_err = 1'b0;
`endif

    assign rd_word        = cur_err ? '0 : mem[idx];
    assign o_mem_rd_valid = enable && (state_q == RD_RESP);
    assign o_mem_wr_ready = enable && (state_q == WR_RESP);
    assign o_mem_err      = (o_mem_rd_valid || o_mem_wr_ready) && cur_err;
    assign o_mem_rd_data  = o_mem_rd_valid ? rd_word : rd_data_q;
    assign wr_fire        = o_mem_wr_ready && !cur_err;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cur_addr_d     = cur_addr_q;
        cur_data_d     = cur_data_q;
        cur_strb_d     = cur_strb_q;
        pend_rd_d      = pend_rd_q;
        pend_rd_addr_d = pend_rd_addr_q;
        pend_wr_d      = pend_wr_q;
        pend_wr_addr_d = pend_wr_addr_q;
        pend_wr_data_d = pend_wr_data_q;
        pend_wr_strb_d = pend_wr_strb_q;
        rd_data_d      = o_mem_rd_valid ? rd_word : rd_data_q;

        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (pend_wr_q || i_mem_wr_valid) begin
                        state_d = (LATENCY == 0) ? WR_RESP : WR_WAIT;
                        cnt_d   = 4'd0;
                        if (pend_wr_q) begin
                            // Oldest write first; a new write refills the freed slot.
                            cur_addr_d     = pend_wr_addr_q;
                            cur_data_d     = pend_wr_data_q;
                            cur_strb_d     = pend_wr_strb_q;
                            pend_wr_d      = i_mem_wr_valid;
                            pend_wr_addr_d = i_mem_wr_addr;
                            pend_wr_data_d = i_mem_wr_data;
                            pend_wr_strb_d = i_mem_wr_strb;
                        end else begin
                            cur_addr_d = i_mem_wr_addr;
                            cur_data_d = i_mem_wr_data;
                            cur_strb_d = i_mem_wr_strb;
                        end
                        if (i_mem_rd_ready && !pend_rd_q) begin
                            pend_rd_d      = 1'b1;
                            pend_rd_addr_d = i_mem_rd_addr;
                        end
                    end else if (pend_rd_q || i_mem_rd_ready) begin
                        state_d = (LATENCY == 0) ? RD_RESP : RD_WAIT;
                        cnt_d   = 4'd0;
                        if (pend_rd_q) begin
                            cur_addr_d     = pend_rd_addr_q;
                            pend_rd_d      = i_mem_rd_ready;
                            pend_rd_addr_d = i_mem_rd_addr;
                        end else begin
                            cur_addr_d = i_mem_rd_addr;
                        end
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (cnt_q == LAT_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = (state_q == RD_WAIT) ? RD_RESP : WR_RESP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                RD_RESP, WR_RESP: state_d = IDLE;
                default:          state_d = IDLE;
            endcase

            if (state_q != IDLE) begin
                if (i_mem_wr_valid && !pend_wr_q) begin
                    pend_wr_d      = 1'b1;
                    pend_wr_addr_d = i_mem_wr_addr;
                    pend_wr_data_d = i_mem_wr_data;
                    pend_wr_strb_d = i_mem_wr_strb;
                end
                if (i_mem_rd_ready && !pend_rd_q) begin
                    pend_rd_d      = 1'b1;
                    pend_rd_addr_d = i_mem_rd_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cur_addr_q     <= '0;
            cur_data_q     <= '0;
            cur_strb_q     <= '0;
            pend_rd_q      <= 1'b0;
            pend_rd_addr_q <= '0;
            pend_wr_q      <= 1'b0;
            pend_wr_addr_q <= '0;
            pend_wr_data_q <= '0;
            pend_wr_strb_q <= '0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cur_addr_q     <= cur_addr_d;
            cur_data_q     <= cur_data_d;
            cur_strb_q     <= cur_strb_d;
            pend_rd_q      <= pend_rd_d;
            pend_rd_addr_q <= pend_rd_addr_d;
            pend_wr_q      <= pend_wr_d;
            pend_wr_addr_q <= pend_wr_addr_d;
            pend_wr_data_q <= pend_wr_data_d;
            pend_wr_strb_q <= pend_wr_strb_d;
            rd_data_q      <= rd_data_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (cur_strb_q[b]) begin
                    mem[idx][b*8 +: 8] <= cur_data_q[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_mu_data_mem_responder.sv
// tb/tb_riscv_mu_data_mem_responder.sv - directed bench for riscv_mu_data_mem_responder (LATENCY=2, DEPTH=1024)
module tb_riscv_mu_data_mem_responder;

    logic        clk = 1'b0;
    logic        nreset;
    logic        enable;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_ready;
    logic        err;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int          n;
    int          c;
    logic [31:0] d;
    logic        e;

    riscv_mu_data_mem_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(1024), .LATENCY(2)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .enable         (enable),
        .i_mem_rd_ready (rd_req),
        .i_mem_rd_addr  (rd_addr),
        .o_mem_rd_valid (rd_valid),
        .o_mem_rd_data  (rd_data),
        .i_mem_wr_valid (wr_req),
        .i_mem_wr_addr  (wr_addr),
        .i_mem_wr_data  (wr_data),
        .i_mem_wr_strb  (wr_strb),
        .o_mem_wr_ready (wr_ready),
        .o_mem_err      (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue_wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
        wr_req = 1'b1; wr_addr = a; wr_data = v; wr_strb = s;
        step();
        wr_req = 1'b0;
    endtask

    task automatic issue_rd(input logic [31:0] a);
        rd_req = 1'b1; rd_addr = a;
        step();
        rd_req = 1'b0;
    endtask

    // Steps until the selected pulse is visible (bounded), captures data/err, then steps past it.
    task automatic wait_pulse(input bit is_rd, output int steps, output logic [31:0] data, output logic er);
        steps = 0;
        while (!(is_rd ? rd_valid : wr_ready) && steps < 40) begin
            step();
            steps++;
        end
        data = rd_data;
        er   = err;
        step();
    endtask

    task automatic count_pulses(input bit is_rd, input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (is_rd ? rd_valid : wr_ready) cnt++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nreset = 1'b0; enable = 1'b1;
        rd_req = 1'b0; rd_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        repeat (3) step();
        check("reset_rd_valid", rd_valid, 0);
        check("reset_wr_ready", wr_ready, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_err", err, 0);
        nreset = 1'b1;
        step();

        // Accept cycle N, response in N+3: two steps after the issue step.
        issue_wr(32'h10, 32'hDEADBEEF, 4'hF);
        wait_pulse(0, n, d, e);
        check("wr_latency", n, 2);
        issue_rd(32'h10);
        wait_pulse(1, n, d, e);
        check("rd_latency", n, 2);
        check("rd_data_10", d, 32'hDEADBEEF);
        check("rd_err_10", e, 0);
        check("rd_data_hold", rd_data, 32'hDEADBEEF);

        issue_wr(32'h20, 32'h11223344, 4'hF);
        wait_pulse(0, n, d, e);
        issue_wr(32'h20, 32'hAABBCCDD, 4'h5);
        wait_pulse(0, n, d, e);
        check("strb5_latency", n, 2);
        issue_rd(32'h20);
        wait_pulse(1, n, d, e);
        check("strb5_data", d, 32'h11BB33DD);
        issue_wr(32'h20, 32'hFFFFFFFF, 4'h0);
        wait_pulse(0, n, d, e);
        check("strb0_ready", n, 2);
        issue_rd(32'h20);
        wait_pulse(1, n, d, e);
        check("strb0_data", d, 32'h11BB33DD);

        // Read and write together: write first, read taken from its slot in the following IDLE cycle.
        rd_req = 1'b1; rd_addr = 32'h30;
        wr_req = 1'b1; wr_addr = 32'h30; wr_data = 32'h55; wr_strb = 4'hF;
        step();
        rd_req = 1'b0; wr_req = 1'b0;
        wait_pulse(0, n, d, e);
        check("simul_wr_first", n, 2);
        wait_pulse(1, n, d, e);
        check("simul_rd_after", n, 3);
        check("simul_rd_data", d, 32'h55);

        issue_wr(32'h40, 32'h77, 4'hF);
        issue_rd(32'h30);
        issue_rd(32'h40);
        wait_pulse(0, n, d, e);
        check("busy_wr_now", n, 0);
        wait_pulse(1, n, d, e);
        check("busy_rd_latency", n, 3);
        check("busy_rd_first_addr", d, 32'h55);
        count_pulses(1, 20, c);
        check("busy_no_second", c, 0);

        issue_rd(32'h10);
        enable = 1'b0;
        count_pulses(1, 4, c);
        check("stall_no_pulse", c, 0);
        enable = 1'b1;
        wait_pulse(1, n, d, e);
        check("stall_remaining", n, 2);
        check("stall_data", d, 32'hDEADBEEF);

        issue_rd(32'h20);
        step();
        step();
        enable = 1'b0;
        #1;
        check("resp_stall_forced0", rd_valid, 0);
        step();
        step();
        enable = 1'b1;
        #1;
        check("resp_stall_release", rd_valid, 1);
        check("resp_stall_data", rd_data, 32'h11BB33DD);
        step();
        check("resp_stall_single", rd_valid, 0);
        check("resp_stall_hold", rd_data, 32'h11BB33DD);

        issue_wr(32'h10, 32'h0, 4'hF);
        nreset = 1'b0;
        #1;
        check("midrst_wr_ready", wr_ready, 0);
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_rd_data", rd_data, 0);
        check("midrst_err", err, 0);
        step();
        step();
        nreset = 1'b1;
        count_pulses(0, 10, c);
        check("midrst_no_ready", c, 0);
        issue_rd(32'h10);
        wait_pulse(1, n, d, e);
        check("midrst_array_kept", d, 32'hDEADBEEF);

        issue_wr(32'h0, 32'hCAFEF00D, 4'hF);
        wait_pulse(0, n, d, e);
`ifdef DMEM_ADDR_CHECK_EN
        issue_rd(32'h2);
        wait_pulse(1, n, d, e);
        check("chk_misalign_err", e, 1);
        check("chk_misalign_data", d, 0);
        issue_rd(32'h1000);
        wait_pulse(1, n, d, e);
        check("chk_range_err", e, 1);
        check("chk_range_data", d, 0);
        issue_wr(32'h1000, 32'h12345678, 4'hF);
        wait_pulse(0, n, d, e);
        check("chk_wr_err", e, 1);
        issue_rd(32'h0);
        wait_pulse(1, n, d, e);
        check("chk_wr_no_access", d, 32'hCAFEF00D);
`else
        issue_rd(32'h1000);
        wait_pulse(1, n, d, e);
        check("wrap_data", d, 32'hCAFEF00D);
        check("wrap_err", e, 0);
        issue_rd(32'h2);
        wait_pulse(1, n, d, e);
        check("lowbits_ignored", d, 32'hCAFEF00D);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
